// File: rtl/csi2_pkt_parser.sv
// csi2_pkt_parser: CSI-2 header/ECC parser, long-packet payload streamer and short-packet strobe decoder
module csi2_pkt_parser #(
  parameter bit          CHECK_ECC = 1'b1,
  parameter logic [15:0] MAX_WC    = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic [31:0] tdata_o,
  output logic        tvalid_o,
  output logic [3:0]  tkeep_o,
  output logic        tlast_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        eop_o,
  output logic        ecc_err_o
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_TAIL} state_t;
  state_t state, state_n;
  logic [16:0] rem, rem_n;
  logic [31:0] tdata_n;
  logic [3:0]  tkeep_n;
  logic [1:0]  vc_n;
  logic [5:0]  dt_n, ecc;
  logic [15:0] wc;
  logic tvalid_n, tlast_n, fs_n, fe_n, ls_n, le_n, eop_n, err_n, is_long, hdr_bad;
  assign wc = data_i[23:8];
  // Hamming parity: each bit is the XOR of the header bits it covers
  assign ecc[0] = ^(data_i[23:0] & 24'hF12CB7);
  assign ecc[1] = ^(data_i[23:0] & 24'hF2555B);
  assign ecc[2] = ^(data_i[23:0] & 24'h749A6D);
  assign ecc[3] = ^(data_i[23:0] & 24'hB8E38E);
  assign ecc[4] = ^(data_i[23:0] & 24'hDF03F0);
  assign ecc[5] = ^(data_i[23:0] & 24'hEFFC00);
  assign is_long = data_i[5:4] != 2'b00;
  assign hdr_bad = (CHECK_ECC && ecc != data_i[29:24]) || (is_long && {1'b0, wc} > {1'b0, MAX_WC});
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    tdata_n  = '0;
    tvalid_n = 1'b0;
    tkeep_n  = '0;
    tlast_n  = 1'b0;
    vc_n     = vc_o;
    dt_n     = dt_o;
    fs_n     = 1'b0;
    fe_n     = 1'b0;
    ls_n     = 1'b0;
    le_n     = 1'b0;
    eop_n    = 1'b0;
    err_n    = 1'b0;
    if (!enable_i) state_n = IDLE;
    else if (valid_i) begin
      case (state)
        IDLE: begin
          if (hdr_bad) begin
            err_n = 1'b1;
            eop_n = 1'b1;
          end else begin
            vc_n = data_i[7:6];
            dt_n = data_i[5:0];
            if (!is_long) begin
              eop_n = 1'b1;
              fs_n  = data_i[5:0] == 6'h00;
              fe_n  = data_i[5:0] == 6'h01;
              ls_n  = data_i[5:0] == 6'h02;
              le_n  = data_i[5:0] == 6'h03;
            end else begin
              rem_n   = {1'b0, wc};
              state_n = (wc == 16'd0) ? CRC_TAIL : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          tvalid_n = 1'b1;
          tdata_n  = data_i;
          if (rem > 17'd4) begin
            tkeep_n = 4'hF;
            rem_n   = rem - 17'd4;
          end else begin
            // both CRC bytes fit in this word when at most two payload bytes are used
            tlast_n = 1'b1;
            tkeep_n = 4'hF >> (3'd4 - rem[2:0]);
            eop_n   = rem <= 17'd2;
            state_n = (rem <= 17'd2) ? IDLE : CRC_TAIL;
          end
        end
        default: begin
          eop_n   = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rem           <= '0;
      tdata_o       <= '0;
      tvalid_o      <= 1'b0;
      tkeep_o       <= '0;
      tlast_o       <= 1'b0;
      vc_o          <= '0;
      dt_o          <= '0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      line_start_o  <= 1'b0;
      line_end_o    <= 1'b0;
      eop_o         <= 1'b0;
      ecc_err_o     <= 1'b0;
    end else begin
      state         <= state_n;
      rem           <= rem_n;
      tdata_o       <= tdata_n;
      tvalid_o      <= tvalid_n;
      tkeep_o       <= tkeep_n;
      tlast_o       <= tlast_n;
      vc_o          <= vc_n;
      dt_o          <= dt_n;
      frame_start_o <= fs_n;
      frame_end_o   <= fe_n;
      line_start_o  <= ls_n;
      line_end_o    <= le_n;
      eop_o         <= eop_n;
      ecc_err_o     <= err_n;
    end
  end
endmodule

// File: tb/tb_csi2_pkt_parser.sv
// tb_csi2_pkt_parser: random CSI-2 packets against a byte-level reference model with a timed scoreboard
module tb_csi2_pkt_parser;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, valid = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] tdata, b_tdata;
  logic [3:0]  tkeep, b_tkeep;
  logic [1:0]  vc, b_vc;
  logic [5:0]  dt, b_dt;
  logic tvalid, tlast, fs, fe, ls, le, eop, err;
  logic b_tvalid, b_tlast, b_fs, b_fe, b_ls, b_le, b_eop, b_err;
  int vecs = 0, errs = 0, cyc = 0;
  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic tlast, tvalid, eop, err, fs, fe, ls, le;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } ev_t;
  ev_t exp_q[$];
  int  due_q[$];
  logic [1:0] ref_vc = '0;
  logic [5:0] ref_dt = '0;
  // syndrome column of each header bit D0..D23
  localparam logic [5:0] COL [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  csi2_pkt_parser dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .data_i(data), .valid_i(valid),
    .tdata_o(tdata), .tvalid_o(tvalid), .tkeep_o(tkeep), .tlast_o(tlast), .vc_o(vc), .dt_o(dt),
    .frame_start_o(fs), .frame_end_o(fe), .line_start_o(ls), .line_end_o(le),
    .eop_o(eop), .ecc_err_o(err));

  csi2_pkt_parser #(.CHECK_ECC(1'b0), .MAX_WC(16'd100)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .data_i(data), .valid_i(valid),
    .tdata_o(b_tdata), .tvalid_o(b_tvalid), .tkeep_o(b_tkeep), .tlast_o(b_tlast), .vc_o(b_vc), .dt_o(b_dt),
    .frame_start_o(b_fs), .frame_end_o(b_fe), .line_start_o(b_ls), .line_end_o(b_le),
    .eop_o(b_eop), .ecc_err_o(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] ecc_of(logic [23:0] d);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= COL[i];
    return e;
  endfunction

  function automatic ev_t base();
    ev_t e = '0;
    e.vc = ref_vc;
    e.dt = ref_dt;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1 valid = 1'b0;
    data = $urandom;
  endtask

  task automatic drive(logic [31:0] w, output int due);
    repeat ($urandom_range(0, 2)) idle_cycle();
    @(posedge clk);
    #1 valid = 1'b1;
    data = w;
    due = cyc + 1;
  endtask

  task automatic push(ev_t e, int due);
    exp_q.push_back(e);
    due_q.push_back(due);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    valid = 1'b0;
    #1 chk("reset_clear", 64'({tdata, tvalid, tkeep, tlast, vc, dt, fs, fe, ls, le, eop, err}), 64'd0);
    exp_q.delete();
    due_q.delete();
    ref_vc = '0;
    ref_dt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // chk_b: 1 = second parser must decode a frame start, 2 = it must flag a header error
  task automatic send_pkt(logic [1:0] pvc, logic [5:0] pdt, logic [15:0] wc, bit flip, bit seq, int chk_b, int abort);
    logic [31:0] hdr, w;
    logic [7:0] bytes[$];
    int due, nw, n;
    ev_t e;
    hdr[23:0] = {wc, pvc, pdt};
    hdr[29:24] = ecc_of(hdr[23:0]) ^ (flip ? 6'(1 << $urandom_range(0, 5)) : 6'd0);
    hdr[31:30] = 2'($urandom);
    drive(hdr, due);
    if (flip) begin
      e = base();
      e.err = 1'b1;
      e.eop = 1'b1;
      push(e, due);
    end else begin
      ref_vc = pvc;
      ref_dt = pdt;
      if (pdt < 6'h10) begin
        e = base();
        e.eop = 1'b1;
        e.fs = pdt == 6'h00;
        e.fe = pdt == 6'h01;
        e.ls = pdt == 6'h02;
        e.le = pdt == 6'h03;
        push(e, due);
      end
    end
    if (chk_b == 1) begin
      idle_cycle();
      @(negedge clk);
      chk("no_ecc_check_parse", {61'd0, b_fs, b_err, b_eop}, 64'b101);
    end
    if (chk_b == 2) begin
      idle_cycle();
      @(negedge clk);
      chk("max_wc_error", {61'd0, b_fs, b_err, b_eop}, 64'b011);
    end
    if (flip || pdt < 6'h10) return;
    nw = (int'(wc) + 5) / 4;
    for (int k = 0; k < nw * 4; k++) bytes.push_back((seq && k < int'(wc)) ? 8'(k) : 8'($urandom));
    for (int i = 0; i < nw; i++) begin
      if (abort > 0 && i == abort) begin
        do_reset();
        return;
      end
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      drive(w, due);
      n = int'(wc) - 4 * i;
      n = n > 4 ? 4 : (n < 0 ? 0 : n);
      e = base();
      if (n > 0) begin
        e.tvalid = 1'b1;
        e.tdata = w;
        e.tkeep = 4'((1 << n) - 1);
        e.tlast = int'(wc) - 4 * i <= 4;
      end
      // eop follows the word that carries the second CRC byte
      e.eop = (4 * i <= int'(wc) + 1) && (int'(wc) + 1 < 4 * i + 4);
      if (e.tvalid || e.eop) push(e, due);
    end
  endtask

  always @(negedge clk) begin
    ev_t a, e;
    int d;
    if (!rst && (tvalid || eop || err || fs || fe || ls || le)) begin
      a = {tdata, tkeep, tlast, tvalid, eop, err, fs, fe, ls, le, vc, dt};
      if (exp_q.size() == 0) chk("unexpected_output", 64'(a), 64'd0);
      else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (!e.tvalid) a.tdata = '0;
        chk("output_event", 64'(a), 64'(e));
        chk("output_cycle", 64'(cyc), 64'(d));
      end
    end
  end

  initial begin
    logic [5:0] rdt;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({tdata, tvalid, tkeep, tlast, vc, dt, fs, fe, ls, le, eop, err}), 64'd0);
    send_pkt(2'd1, 6'h00, 16'h0005, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd0, 6'h2B, 16'd8, 1'b0, 1'b1, 0, 0);
    send_pkt(2'd2, 6'h2A, 16'd5, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd3, 6'h24, 16'd7, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd0, 6'h12, 16'd0, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd1, 6'h00, 16'h0005, 1'b1, 1'b0, 1, 0);
    send_pkt(2'd2, 6'h2B, 16'd12, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd1, 6'h03, 16'h1234, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd0, 6'h1E, 16'd200, 1'b0, 1'b0, 2, 0);
    for (int p = 0; p < 60; p++) begin
      r = $urandom_range(0, 7);
      rdt = (r < 3) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 63));
      send_pkt(2'($urandom), rdt, rdt < 6'h10 ? 16'($urandom) : 16'($urandom_range(0, 40)), r == 0, 1'b0, 0, 0);
    end
    send_pkt(2'd3, 6'h2B, 16'd40, 1'b0, 1'b0, 0, 3);
    send_pkt(2'd2, 6'h01, 16'd0, 1'b0, 1'b0, 0, 0);
    send_pkt(2'd1, 6'h2C, 16'd6, 1'b0, 1'b0, 0, 0);
    repeat (6) idle_cycle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/csi2_pkt_parser.md
Name: csi2_pkt_parser

Overview:
- Consumes the 32-bit word stream produced by the D-PHY slave in the byte-clock domain.
- Parses CSI-2 packet headers, checks the header ECC, and forwards long-packet payload as a byte-enabled stream with an end marker.
- Strips the CRC trailer and decodes short packets into sync strobes.
- Pulses end-of-packet back to the PHY (its phy_rst_i) so lane/word alignment re-arms for the next burst.

Parameters:
- CHECK_ECC, 1, 1 = verify header ECC and drop packets that fail; 0 = skip the check.
- MAX_WC, 16'hFFFF, long packets with WC > MAX_WC are treated as header errors.

Ports:
- clk_i  in  1  byte clock, same as the PHY clk_o
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  parsing enable; when low, inputs are ignored
- data_i  in  32  PHY word; byte0 = data_i[7:0] is the first byte received on the wire
- valid_i  in  1  data_i qualifier; may deassert for any number of cycles mid-packet
- tdata_o  out  32  payload word, same byte order as data_i
- tvalid_o  out  1  payload word valid
- tkeep_o  out  4  byte enables for tdata_o
- tlast_o  out  1  last payload word of the packet
- vc_o  out  2  virtual channel of the current/last packet
- dt_o  out  6  data type of the current/last packet
- frame_start_o / frame_end_o / line_start_o / line_end_o  out  1 each  short-packet strobes
- eop_o  out  1  end-of-packet pulse to the PHY
- ecc_err_o  out  1  header error pulse

Behaviour:
- All outputs are registered; reset value of every output is 0. Reset is asynchronous, may occur mid-packet, and returns the FSM to IDLE.
- Header word fields: DI = byte0 (VC = [7:6], DT = [5:0]); WC = {byte2, byte1}; ECC = byte3[5:0].
- ECC is the MIPI CSI-2 v1.1 6-bit Hamming code over the 24 bits {byte2, byte1, byte0}; byte3[7:6] is ignored.
- States: IDLE, PAYLOAD, CRC_TAIL. A transition occurs only on a cycle with valid_i = 1 and enable_i = 1.
- IDLE, on a header word:
  - CHECK_ECC = 1 and ECC mismatch, or long packet with WC > MAX_WC: pulse ecc_err_o and eop_o next cycle, stay IDLE.
  - DT < 6'h10 (short packet): latch vc_o/dt_o; next cycle pulse the matching strobe (0x00 frame_start, 0x01 frame_end, 0x02 line_start, 0x03 line_end; other short DTs give no strobe) together with eop_o; stay IDLE.
  - DT >= 6'h10 (long packet): latch vc_o/dt_o, load rem = WC (17-bit arithmetic), go to PAYLOAD; if WC = 0 go to CRC_TAIL instead.
- PAYLOAD, each valid word:
  - Output the word 1 cycle later with tvalid_o = 1.
  - If rem > 4: tkeep = 4'b1111, rem -= 4.
  - Else this is the last payload word: tlast_o = 1; tkeep = 4'b0001 / 0011 / 0111 / 1111 for rem = 1 / 2 / 3 / 4.
  - After the last payload word, go to IDLE with eop_o pulsed if rem <= 2 (both CRC bytes are inside this word). Otherwise go to CRC_TAIL; crc_left = 2 - (4 - rem) CRC bytes remain.
- CRC_TAIL: the next valid word holds the remaining CRC bytes. Consume it with no tvalid_o, pulse eop_o, go to IDLE. With WC = 0 the CRC word itself is this word.
- Padding bytes after the CRC in the final word are discarded.
- The CRC value is not checked.
- enable_i low: FSM held in IDLE (a mid-packet deassert aborts to IDLE with no eop_o); outputs other than vc_o/dt_o stay 0.
- Latency header -> strobe/eop = 1 cycle; payload in -> out = 1 cycle.
- No backpressure: the downstream consumer must accept every tvalid_o.
- eop_o and tlast_o can be high in the same cycle.
- Strobes, eop_o and ecc_err_o are single-cycle pulses.

Test Plan:
- Short FS header, VC = 1, DT = 0x00, WC = 0x0005, valid ECC from the bench reference model -> one cycle later frame_start_o = 1 and eop_o = 1, vc_o = 1, no tvalid_o.
- Long packet DT = 0x2B, WC = 8, payload 0x03020100, 0x07060504, then CRC word -> two tvalid_o beats, tkeep 1111 on both, tlast_o on the 2nd beat; eop_o one cycle after the CRC word.
- WC = 5 -> beats tkeep 1111, then 0001 with tlast_o = 1; the CRC bytes sit in bytes 1–2 of the last word, so eop_o is with tlast_o and there is no CRC_TAIL.
- WC = 7 -> last beat tkeep 0111 with tlast_o; one CRC byte is in the next word, which is consumed silently, then eop_o.
- Header with one ECC bit flipped, CHECK_ECC = 1 -> ecc_err_o and eop_o pulse, no payload output; the following valid packet parses correctly. With CHECK_ECC = 0 the same header is parsed as a packet.
- Reset asserted mid-PAYLOAD with valid_i gaps -> all outputs 0 immediately; the next header is parsed from IDLE.
